// File: rtl/div_seq_pkg.sv
// Shared constants and types for the sequential radix-2 divider.
package div_seq_pkg;

  localparam int unsigned DataW      = 32;
  localparam int unsigned DoubleRegW = 64;
  localparam int unsigned WorkW      = 2 * DataW + 1;
  localparam int unsigned CntW       = 6;

  // State codes kept beside the other pipeline-wide constants.
  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef logic [DoubleRegW-1:0] double_reg_t;

  typedef enum logic [1:0] {
    ST_FREE   = DivFree,
    ST_BYZERO = DivByZero,
    ST_ON     = DivOn,
    ST_END    = DivEnd
  } div_state_t;

  // Two's complement negate when requested, otherwise pass through.
  function automatic logic [DataW-1:0] cond_neg(input logic [DataW-1:0] v, input logic neg);
    return neg ? DataW'(-v) : v;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between EX and the divider.
interface div_seq_if;
  import div_seq_pkg::*;

  logic              signed_div_i;
  logic [DataW-1:0]  opdata1_i;
  logic [DataW-1:0]  opdata2_i;
  logic              start_i;
  logic              annul_i;
  double_reg_t       result_o;
  logic              ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; one quotient bit per clock.
module div_seq
  import div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  div_seq_if.slave    bus
);

  div_state_t         state;
  logic [CntW-1:0]    cnt;
  logic [WorkW-1:0]   work;
  logic [DataW-1:0]   divisor;
  logic               sgn_div;
  logic               sign1;
  logic               sign2;
  double_reg_t        result_q;
  logic               ready_q;

  logic [DataW:0]     trial;
  logic               neg1;
  logic               neg2;
  logic [DataW-1:0]   q_fix;
  logic [DataW-1:0]   r_fix;

  // Trial subtract of the upper partial remainder, plus operand/result sign fixups.
  always_comb begin
    trial = {1'b0, work[2*DataW-1:DataW]} - {1'b0, divisor};
    neg1  = bus.signed_div_i & bus.opdata1_i[DataW-1];
    neg2  = bus.signed_div_i & bus.opdata2_i[DataW-1];
    q_fix = cond_neg(work[DataW-1:0], sgn_div & (sign1 ^ sign2));
    r_fix = cond_neg(work[WorkW-1:DataW+1], sgn_div & sign1);
  end

  // Control FSM and datapath; annul overrides every other transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FREE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      sgn_div  <= 1'b0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else if (bus.annul_i) begin
      state    <= ST_FREE;
      cnt      <= '0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else begin
      case (state)
        ST_FREE: begin
          if (bus.start_i == DivStart) begin
            sgn_div <= bus.signed_div_i;
            sign1   <= bus.opdata1_i[DataW-1];
            sign2   <= bus.opdata2_i[DataW-1];
            if (bus.opdata2_i == '0) begin
              state <= ST_BYZERO;
            end else begin
              state   <= ST_ON;
              cnt     <= '0;
              work    <= {{DataW{1'b0}}, cond_neg(bus.opdata1_i, neg1), 1'b0};
              divisor <= cond_neg(bus.opdata2_i, neg2);
            end
          end
        end
        ST_BYZERO: begin
          result_q <= '0;
          ready_q  <= DivResultReady;
          state    <= ST_END;
        end
        ST_ON: begin
          if (cnt != CntW'(DataW)) begin
            if (trial[DataW]) begin
              work <= {work[WorkW-2:0], 1'b0};
            end else begin
              work <= {trial[DataW-1:0], work[DataW-1:0], 1'b1};
            end
            cnt <= CntW'(cnt + 1'b1);
          end else begin
            result_q <= {r_fix, q_fix};
            ready_q  <= DivResultReady;
            state    <= ST_END;
          end
        end
        ST_END: begin
          // Result is held until EX drops its request.
          if (bus.start_i == DivStop) begin
            state    <= ST_FREE;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
          end
        end
        default: state <= ST_FREE;
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq against an arithmetic reference model.
module tb_div_seq;
  import div_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  div_seq_if bus();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: truncating division on magnitudes, then sign fixups.
  function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
    logic        na, nb;
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return 64'd0;
    na = sd && a[31];
    nb = sd && b[31];
    ma = na ? 32'(0 - a) : a;
    mb = nb ? 32'(0 - b) : b;
    q  = ma / mb;
    r  = ma % mb;
    if (na != nb) q = 32'(0 - q);
    if (na)       r = 32'(0 - r);
    return {r, q};
  endfunction

  // One full request: latency, result, hold while start high, and release.
  task automatic run_op(input string name, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat,
                        input int hold);
    int n;
    bit seen;
    @(negedge clk);
    bus.signed_div_i = sd;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    @(posedge clk); #1;
    n    = 1;
    seen = bus.ready_o;
    bus.opdata1_i    = $urandom;
    bus.opdata2_i    = $urandom;
    bus.signed_div_i = ~sd;
    while (!seen && n < lat + 4) begin
      @(posedge clk); #1;
      n++;
      seen = bus.ready_o;
    end
    checks++;
    if (!seen || n != lat) begin
      errors++;
      $display("FAIL %s latency: ready seen=%0d at edge %0d, want edge %0d", name, seen, n, lat);
    end
    checks++;
    if (bus.result_o !== exp) begin
      errors++;
      $display("FAIL %s result: got %h want %h (sd=%0d a=%h b=%h)", name, bus.result_o, exp, sd, a, b);
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      checks++;
      if (bus.ready_o !== 1'b1 || bus.result_o !== exp) begin
        errors++;
        $display("FAIL %s hold: ready=%b result=%h want ready=1 result=%h", name, bus.ready_o, bus.result_o, exp);
      end
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      errors++;
      $display("FAIL %s release: ready=%b result=%h want 0/0", name, bus.ready_o, bus.result_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (bus.ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0", bus.ready_o);
    end
    checks++;
    if (bus.result_o !== 64'd0) begin
      errors++;
      $display("FAIL reset_result: got %h want 0", bus.result_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op("divu_100_7",   1'b0, 32'd100,        32'd7,          {32'h00000002, 32'h0000000E}, 34, 2);
    run_op("div_m7_2",     1'b1, 32'hFFFFFFF9,   32'h00000002,   {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 0);
    run_op("div_7_m2",     1'b1, 32'h00000007,   32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD}, 34, 0);
    run_op("div_overflow", 1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h00000000, 32'h80000000}, 34, 0);
    run_op("divu_max_1",   1'b0, 32'hFFFFFFFF,   32'h00000001,   {32'h00000000, 32'hFFFFFFFF}, 34, 0);
  endtask

  task automatic test_by_zero();
    run_op("div_by_zero_s", 1'b1, 32'h12345678, 32'd0, 64'd0, 2, 1);
    run_op("div_by_zero_u", 1'b0, 32'hFFFFFFFF, 32'd0, 64'd0, 2, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      logic        sd;
      logic [31:0] a, b;
      sd = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'(0 - b);
      run_op("random", sd, a, b, model(sd, a, b), (b == 32'd0) ? 2 : 34, 0);
    end
  endtask

  task automatic test_annul();
    bit seen;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      errors++;
      $display("FAIL annul_clear: ready=%b result=%h want 0/0", bus.ready_o, bus.result_o);
    end
    @(negedge clk);
    bus.annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.ready_o !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL annul_no_ready: ready observed high after annul");
    end
    run_op("after_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, 0);
  endtask

  task automatic test_async_reset();
    int n;
    // Reset during ON.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd500;
    bus.opdata2_i    = 32'd9;
    bus.start_i      = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    #1;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      errors++;
      $display("FAIL rst_on: ready=%b result=%h want 0/0", bus.ready_o, bus.result_o);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst_on", 1'b1, 32'hFFFFFF9C, 32'd7, model(1'b1, 32'hFFFFFF9C, 32'd7), 34, 0);
    // Reset during END.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== {32'd2, 32'd14}) begin
      errors++;
      $display("FAIL rst_end_setup: ready=%b result=%h after %0d edges", bus.ready_o, bus.result_o, n);
    end
    @(posedge clk);
    #2;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    #1;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      errors++;
      $display("FAIL rst_end: ready=%b result=%h want 0/0", bus.ready_o, bus.result_o);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst_end", 1'b0, 32'd81, 32'd9, {32'd0, 32'd9}, 34, 0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    test_reset();
    test_directed();
    test_by_zero();
    test_random();
    test_annul();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
